uart_rx_block: RTL and testbench

UART receiver on the line driven by the tx_block serializer: 8N1, LSB first, idle-high. Oversamples rx_in on a shared 16x baud tick (sample_en) and recovers frames with mid-bit sampling. Delivers each byte with a one-cycle valid pulse, and flags bad stop bits with a one-cycle frame_err pulse. Sits between the pad/loopback wire and the byte consumer; there is no backpressure.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync.sv | 25 ++
 rtl/uart_rx_block.sv | 155 +++++++++++++++
 tb/tb_uart_rx_block.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry
// and the line-level frame layout used by both the serializer and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  // Frame layout: one low start bit, data LSB first, one high stop bit.
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;
  localparam bit   UART_LSB_FIRST = 1'b1;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous pad input. Resets to 1 so an
// idle-high serial line does not look like a start bit on reset release.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw input through the flop chain every clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_block.sv
// UART receiver, 8N1 by default. Oversamples the synchronized line on the
// shared sample_en tick, confirms the start bit at mid-bit, then samples each
// data bit and the stop bit at its centre.
//
// state | meaning
// IDLE  | line idle, waiting for a low sample
// START | counting to the middle of the start bit to reject glitches
// DATA  | sampling data bits at each bit centre, LSB first
// STOP  | sampling the stop bit; good -> valid, low -> frame_err
// BREAK | stop bit was low; wait for the line to go high before rearming
module uart_rx_block
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int DATA_BITS   = UART_DATA_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_en,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  rx_state_t             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;

  uart_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (rx_in),
    .sync_o  (rx_s)
  );

  // Register all receiver state; pulses are rebuilt from defaults every clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  // Next-state logic; everything except the pulses is frozen between ticks.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    if (sample_en) begin
      case (state_q)
        IDLE: begin
          if (rx_s == UART_START_BIT) begin
            state_d = START;
            cnt_d   = '0;
          end
        end

        START: begin
          if (cnt_q == HALF_LAST) begin
            if (rx_s == UART_START_BIT) begin
              state_d   = DATA;
              cnt_d     = '0;
              bit_idx_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        DATA: begin
          if (cnt_q == BIT_LAST) begin
            shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
            cnt_d     = '0;
            bit_idx_d = bit_idx_q + 1'b1;
            if (bit_idx_q == IDX_LAST) begin
              state_d = STOP;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_d = '0;
            if (rx_s == UART_STOP_BIT) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = BREAK;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        BREAK: begin
          if (rx_s == UART_STOP_BIT) begin
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_block.sv
// Directed bench for uart_rx_block: a bench-side serializer drives 8N1 frames
// aligned to sample_en ticks; a monitor records valid/frame_err pulses with
// their tick numbers so frame latency can be checked exactly.
module tb_uart_rx_block;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_en = 1'b0;
  logic       rx_in = 1'b1;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int n_chk = 0;
  int n_pass = 0;

  logic gate = 1'b1;
  int   tick_cnt = 0;
  int   div = 0;

  int         valid_cnt = 0;
  int         ferr_cnt = 0;
  int         valid_tick = 0;
  int         valid_tick_prev = 0;
  int         ferr_tick = 0;
  logic [7:0] valid_data = 8'h00;
  logic [7:0] valid_data_prev = 8'h00;
  logic       busy_at_valid = 1'b1;
  time        valid_time = 0;

  int  start_tick = 0;
  time start_time = 0;

  uart_rx_block #(
    .OVERSAMPLE  (16),
    .DATA_BITS   (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample_en (sample_en),
    .rx_in     (rx_in),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // sample_en on every 4th clock, changed on the falling edge; tick_cnt
  // numbers the tick that the next rising edge will see.
  initial begin
    forever begin
      @(negedge clk);
      if (div == 3) begin
        div = 0;
        sample_en = gate;
        if (gate) tick_cnt++;
      end else begin
        div++;
        sample_en = 1'b0;
      end
    end
  end

  // Record every output pulse with the tick it followed.
  always @(negedge clk) begin
    if (valid) begin
      valid_cnt++;
      valid_tick_prev = valid_tick;
      valid_data_prev = valid_data;
      valid_tick      = tick_cnt;
      valid_data      = data_out;
      busy_at_valid   = busy;
      valid_time      = $time;
    end
    if (frame_err) begin
      ferr_cnt++;
      ferr_tick = tick_cnt;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (!sample_en);
    end
  endtask

  // Serialize one frame starting right after a tick edge. stall_bit >= 0
  // freezes sample_en for 1000 clocks in the middle of that data bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input int stall_bit);
    rx_in = 1'b0;
    start_tick = tick_cnt;
    start_time = $time;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      if (i == stall_bit) begin
        wait_ticks(8);
        gate = 1'b0;
        repeat (500) @(posedge clk);
        @(negedge clk);
        chk("stall_busy", {31'd0, busy}, 32'd1);
        repeat (500) @(posedge clk);
        gate = 1'b1;
        wait_ticks(8);
      end else begin
        wait_ticks(16);
      end
    end
    rx_in = stop_b;
    wait_ticks(16);
  endtask

  int v0, f0, k;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", {24'd0, data_out}, 32'h00);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    wait_ticks(5);

    // Single frame 0xA5
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, -1);
    wait_ticks(10);
    chk("a5_count", valid_cnt - v0, 32'd1);
    chk("a5_data", {24'd0, valid_data}, 32'hA5);
    chk("a5_ferr", ferr_cnt - f0, 32'd0);
    chk("a5_busy_at_valid", {31'd0, busy_at_valid}, 32'd0);
    chk("a5_latency", valid_tick - start_tick, 32'd153);
    @(negedge clk);
    chk("a5_held", {24'd0, data_out}, 32'hA5);

    // Back-to-back 0x00 then 0xFF
    v0 = valid_cnt;
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    wait_ticks(10);
    chk("b2b_count", valid_cnt - v0, 32'd2);
    chk("b2b_first", {24'd0, valid_data_prev}, 32'h00);
    chk("b2b_second", {24'd0, valid_data}, 32'hFF);
    chk("b2b_spacing", valid_tick - valid_tick_prev, 32'd160);

    // Glitch: 4 ticks low rejected at mid start bit
    v0 = valid_cnt; f0 = ferr_cnt;
    rx_in = 1'b0;
    k = tick_cnt;
    wait_ticks(4);
    rx_in = 1'b1;
    @(negedge clk);
    chk("glitch_busy_hi", {31'd0, busy}, 32'd1);
    wait_ticks(8);
    @(negedge clk);
    chk("glitch_busy_lo", {31'd0, busy}, 32'd0);
    wait_ticks(10);
    chk("glitch_valid", valid_cnt - v0, 32'd0);
    chk("glitch_ferr", ferr_cnt - f0, 32'd0);
    send_frame(8'h3C, 1'b1, -1);
    wait_ticks(10);
    chk("3c_count", valid_cnt - v0, 32'd1);
    chk("3c_data", {24'd0, valid_data}, 32'h3C);

    // Framing error on 0x81, line held low, then 0x5A
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h81, 1'b0, -1);
    wait_ticks(40);
    @(negedge clk);
    chk("ferr_count", ferr_cnt - f0, 32'd1);
    chk("ferr_latency", ferr_tick - start_tick, 32'd153);
    chk("ferr_no_valid", valid_cnt - v0, 32'd0);
    chk("ferr_data_kept", {24'd0, data_out}, 32'h3C);
    chk("ferr_break_busy", {31'd0, busy}, 32'd1);
    rx_in = 1'b1;
    wait_ticks(4);
    @(negedge clk);
    chk("break_exit", {31'd0, busy}, 32'd0);
    send_frame(8'h5A, 1'b1, -1);
    wait_ticks(10);
    chk("5a_count", valid_cnt - v0, 32'd1);
    chk("5a_data", {24'd0, valid_data}, 32'h5A);
    chk("5a_ferr", ferr_cnt - f0, 32'd1);

    // Reset in the middle of bit 3 of 0xC3
    v0 = valid_cnt; f0 = ferr_cnt;
    rx_in = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 3; i++) begin
      rx_in = 1'((8'hC3 >> i) & 8'h01);
      wait_ticks(16);
    end
    rx_in = 1'b0;
    wait_ticks(8);
    @(negedge clk);
    chk("mid_busy_pre", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_data", {24'd0, data_out}, 32'h00);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_valid", {31'd0, valid}, 32'd0);
    rx_in = 1'b1;
    #10 rst_n = 1'b1;
    wait_ticks(20);
    chk("mid_no_valid", valid_cnt - v0, 32'd0);
    chk("mid_no_ferr", ferr_cnt - f0, 32'd0);
    send_frame(8'h96, 1'b1, -1);
    wait_ticks(10);
    chk("96_count", valid_cnt - v0, 32'd1);
    chk("96_data", {24'd0, valid_data}, 32'h96);

    // Tick gating: 1000-clock stall inside bit 3 of 0x6E
    v0 = valid_cnt;
    send_frame(8'h6E, 1'b1, 3);
    wait_ticks(10);
    chk("gate_count", valid_cnt - v0, 32'd1);
    chk("gate_data", {24'd0, valid_data}, 32'h6E);
    chk("gate_ticks", valid_tick - start_tick, 32'd153);
    chk("gate_time_shift", {31'd0, (valid_time - start_time) >= 10000}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
